// File: rtl/pipe_collision_scorer_if.sv
// pipe_collision_scorer_if: game state, bird and pipe positions in; collision and score out.
interface pipe_collision_scorer_if;
    logic [1:0] iState;
    logic signed [31:0] iBirdY;
    logic signed [31:0] iPipe1X, iPipe1Y, iPipe2X, iPipe2Y, iPipe3X, iPipe3Y;
    logic oCollision;
    logic [15:0] oScore;
    logic oScoreTick;
    modport master (
        output iState, iBirdY, iPipe1X, iPipe1Y, iPipe2X, iPipe2Y, iPipe3X, iPipe3Y,
        input oCollision, oScore, oScoreTick
    );
    modport slave (
        input iState, iBirdY, iPipe1X, iPipe1Y, iPipe2X, iPipe2Y, iPipe3X, iPipe3Y,
        output oCollision, oScore, oScoreTick
    );
endinterface

// File: rtl/pipe_collision_scorer.sv
// pipe_collision_scorer: round-robin pipe/ground collision check and saturating pass score.
module pipe_collision_scorer #(
    parameter int BIRD_X = 100,
    parameter int BIRD_SIZE = 24,
    parameter int PIPE_WIDTH = 52,
    parameter int PIPE_GAP_HEIGHT = 100,
    parameter int GROUND_Y = 430,
    parameter int SCORE_MAX = 9999
) (
    input logic iClock,
    input logic iReset,
    pipe_collision_scorer_if.slave bus
);
    localparam logic signed [31:0] BX = BIRD_X;
    localparam logic signed [31:0] BXR = BIRD_X + BIRD_SIZE;
    localparam logic signed [31:0] BS = BIRD_SIZE;
    localparam logic signed [31:0] PW = PIPE_WIDTH;
    localparam logic signed [31:0] GAP = PIPE_GAP_HEIGHT;
    localparam logic signed [31:0] GY = GROUND_Y;
    localparam logic signed [31:0] INVALID = -1;
    localparam logic [15:0] SMAX = 16'(SCORE_MAX);

    typedef enum logic [2:0] {CAP, P1, P2, P3, GND} sweep_t;

    sweep_t st;
    logic signed [31:0] bird_y;
    logic signed [31:0] px [3];
    logic signed [31:0] py [3];
    logic [2:0] passed;
    logic collision, tick;
    logic [15:0] score;

    logic [1:0] idx;
    logic signed [31:0] x, y;
    logic valid, hit, pass, rearm, inc, gnd_hit;

    // Only one pipe is evaluated per cycle, so a single comparator set is shared.
    always_comb begin
        idx = st == P1 ? 2'd0 : st == P2 ? 2'd1 : 2'd2;
        x = px[idx];
        y = py[idx];
        valid = y != INVALID;
        hit = valid && x < BXR && x + PW > BX && (bird_y < y || bird_y + BS > y + GAP);
        pass = valid && x + PW < BX && !passed[idx];
        rearm = !valid || x >= BXR;
        inc = pass && !collision && score != SMAX;
        gnd_hit = bird_y + BS >= GY || bird_y < 0;
    end

    always_ff @(posedge iClock) begin
        if (iReset || bus.iState == 2'd0) begin
            st <= CAP;
            bird_y <= '0;
            px <= '{default: '0};
            py <= '{default: '0};
            passed <= '0;
            collision <= 1'b0;
            tick <= 1'b0;
            score <= '0;
        end else if (bus.iState[1]) begin
            st <= CAP;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (st)
                CAP: begin
                    bird_y <= bus.iBirdY;
                    px <= '{bus.iPipe1X, bus.iPipe2X, bus.iPipe3X};
                    py <= '{bus.iPipe1Y, bus.iPipe2Y, bus.iPipe3Y};
                    st <= P1;
                end
                P1, P2, P3: begin
                    collision <= collision | hit;
                    passed[idx] <= pass ? 1'b1 : rearm ? 1'b0 : passed[idx];
                    score <= inc ? score + 16'd1 : score;
                    tick <= inc;
                    st <= st == P1 ? P2 : st == P2 ? P3 : GND;
                end
                GND: begin
                    collision <= collision | gnd_hit;
                    st <= CAP;
                end
                default: st <= CAP;
            endcase
        end
    end

    assign bus.oCollision = collision;
    assign bus.oScore = score;
    assign bus.oScoreTick = tick;
endmodule

// File: tb/tb_pipe_collision_scorer.sv
// tb_pipe_collision_scorer: directed stimulus checked every cycle against a sweep-level model.
module tb_pipe_collision_scorer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    int ticks = 0;
    bit chk_en = 1'b0;

    pipe_collision_scorer_if bus ();
    pipe_collision_scorer dut (.iClock(clk), .iReset(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // Model: phase 0 captures, 1..3 judge pipes, 4 judges ground/ceiling.
    int ph = 0;
    longint s_b;
    longint s_x [3];
    longint s_y [3];
    bit m_passed [3];
    bit m_col = 1'b0;
    bit m_tick = 1'b0;
    int m_score = 0;

    task automatic model_pipe(input int k);
        longint px = s_x[k];
        longint py = s_y[k];
        if (py == -1) m_passed[k] = 1'b0;
        else begin
            if (px < 124 && px + 52 > 100 && (s_b < py || s_b + 24 > py + 100)) m_col = 1'b1;
            if (px + 52 < 100 && !m_passed[k]) begin
                m_passed[k] = 1'b1;
                if (!m_col && m_score < 9999) begin
                    m_score++;
                    m_tick = 1'b1;
                end
            end else if (px >= 124) m_passed[k] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        m_tick = 1'b0;
        if (rst || bus.iState == 2'd0) begin
            m_col = 1'b0;
            m_score = 0;
            for (int i = 0; i < 3; i++) m_passed[i] = 1'b0;
            ph = 0;
        end else if (bus.iState >= 2'd2) ph = 0;
        else begin
            if (ph == 0) begin
                s_b = longint'(bus.iBirdY);
                s_x = '{longint'(bus.iPipe1X), longint'(bus.iPipe2X), longint'(bus.iPipe3X)};
                s_y = '{longint'(bus.iPipe1Y), longint'(bus.iPipe2Y), longint'(bus.iPipe3Y)};
            end else if (ph < 4) model_pipe(ph - 1);
            else if (s_b + 24 >= 430 || s_b < 0) m_col = 1'b1;
            ph = (ph + 1) % 5;
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("collision", bus.oCollision, m_col);
            chk("score", bus.oScore, m_score);
            chk("tick", bus.oScoreTick, m_tick);
            if (bus.oScoreTick) ticks++;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pipes(input int x1, input int y1, input int x2, input int y2, input int x3, input int y3);
        bus.iPipe1X = x1; bus.iPipe1Y = y1;
        bus.iPipe2X = x2; bus.iPipe2Y = y2;
        bus.iPipe3X = x3; bus.iPipe3Y = y3;
    endtask

    initial begin
        bus.iState = 2'd1;
        bus.iBirdY = 250;
        pipes(0, -1, 0, -1, 0, -1);
        @(negedge clk);
        chk("reset_collision", bus.oCollision, 0);
        chk("reset_score", bus.oScore, 0);
        chk("reset_tick", bus.oScoreTick, 0);
        chk_en = 1'b1;
        rst = 1'b0;

        pipes(110, 200, 0, -1, 0, -1);
        run(50);
        chk("gap_clear_collision", bus.oCollision, 0);
        chk("gap_clear_score", bus.oScore, 0);

        bus.iBirdY = 190;
        run(10);
        chk("pipe_hit", bus.oCollision, 1);
        bus.iBirdY = 250;
        run(20);
        chk("hit_sticky", bus.oCollision, 1);
        bus.iState = 2'd0;
        run(1);
        chk("idle_clears_collision", bus.oCollision, 0);
        chk("idle_clears_score", bus.oScore, 0);
        bus.iState = 2'd1;

        pipes(0, -1, 0, -1, 0, -1);
        bus.iBirdY = 405;
        run(20);
        chk("ground_clear_405", bus.oCollision, 0);
        bus.iBirdY = 406;
        run(10);
        chk("ground_hit_406", bus.oCollision, 1);
        do_reset();
        bus.iBirdY = 0;
        run(20);
        chk("ceiling_clear_0", bus.oCollision, 0);
        bus.iBirdY = -1;
        run(10);
        chk("ceiling_hit", bus.oCollision, 1);

        do_reset();
        bus.iBirdY = 250;
        pipes(200, 200, 0, -1, 0, -1);
        ticks = 0;
        for (int x = 200; x >= 40; x--) begin
            bus.iPipe1X = x;
            run(5);
        end
        run(1000);
        chk("first_pass_score", bus.oScore, 1);
        chk("first_pass_ticks", ticks, 1);
        chk("first_pass_no_collision", bus.oCollision, 0);
        bus.iPipe1X = 640;
        run(10);
        bus.iPipe1X = 40;
        run(10);
        chk("recycled_pass", bus.oScore, 2);
        pipes(40, 200, 40, -1, 0, -1);
        run(20);
        chk("invalid_no_pass", bus.oScore, 2);

        bus.iState = 2'd2;
        run(10);
        bus.iPipe1X = 640;
        run(10);
        bus.iPipe1X = 40;
        run(10);
        chk("freeze_no_inc", bus.oScore, 2);
        bus.iState = 2'd1;
        run(20);
        chk("resume_still_passed", bus.oScore, 2);
        bus.iPipe1X = 640;
        run(10);
        bus.iState = 2'd3;
        bus.iPipe1X = 40;
        run(20);
        chk("freeze3_no_inc", bus.oScore, 2);
        bus.iState = 2'd1;
        run(10);
        chk("resume_scores", bus.oScore, 3);

        do_reset();
        bus.iBirdY = 250;
        ticks = 0;
        for (int i = 0; i < 3333; i++) begin
            pipes(40, 200, 40, 200, 640, 200);
            run(5);
            pipes(640, 200, 640, 200, 40, 200);
            run(5);
        end
        chk("saturate_score", bus.oScore, 9999);
        chk("saturate_ticks", ticks, 9999);
        pipes(40, 200, 40, 200, 640, 200);
        run(5);
        pipes(640, 200, 640, 200, 40, 200);
        run(5);
        chk("saturated_hold", bus.oScore, 9999);
        chk("saturated_no_tick", ticks, 9999);

        do_reset();
        pipes(0, -1, 110, 200, 0, -1);
        bus.iBirdY = 190;
        run(2);
        chk("pre_p2_clear", bus.oCollision, 0);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        chk("mid_sweep_reset", bus.oCollision, 0);
        run(2);
        chk("restart_cap_p1", bus.oCollision, 0);
        run(1);
        chk("restart_cap_p2_hit", bus.oCollision, 1);
        run(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
